// File: rtl/ddio_out_burst_ctrl.sv
// Burst sequencer for a bank of DDIO output pins: frames valid/ready beats with
// an OE preamble/postamble and a bus turnaround gap, one beat per clk.
module ddio_out_burst_ctrl #(
  parameter int   WIDTH       = 8,
  parameter int   PRE_CYCLES  = 1,
  parameter int   POST_CYCLES = 1,
  parameter int   TURN_CYCLES = 2,
  parameter logic IDLE_H      = 1'b0,
  parameter logic IDLE_L      = 1'b0
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               s_valid,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic [WIDTH-1:0]   datain_h,
  output logic [WIDTH-1:0]   datain_l,
  output logic               oe,
  output logic               clkena,
  output logic               busy,
  output logic               underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_POST,
    S_TURN
  } state_t;

  // Counter load values; a zero-length phase is skipped, so its load is unused.
  localparam logic [7:0] PRE_LOAD  = (PRE_CYCLES  == 0) ? 8'd0 : 8'(PRE_CYCLES  - 1);
  localparam logic [7:0] POST_LOAD = (POST_CYCLES == 0) ? 8'd0 : 8'(POST_CYCLES - 1);
  localparam logic [7:0] TURN_LOAD = (TURN_CYCLES == 0) ? 8'd0 : 8'(TURN_CYCLES - 1);

  localparam logic [WIDTH-1:0] IDLE_H_BUS = {WIDTH{IDLE_H}};
  localparam logic [WIDTH-1:0] IDLE_L_BUS = {WIDTH{IDLE_L}};

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [WIDTH-1:0] datain_h_n, datain_l_n;
  logic             oe_n, clkena_n, underrun_n;

  assign s_ready = (state == S_DATA);
  assign busy    = (state != S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    datain_h_n = IDLE_H_BUS;
    datain_l_n = IDLE_L_BUS;
    oe_n       = 1'b0;
    clkena_n   = 1'b0;
    underrun_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (s_valid) begin
          if (PRE_CYCLES == 0) begin
            state_n = S_DATA;
          end else begin
            state_n = S_PRE;
            cnt_n   = PRE_LOAD;
          end
        end
      end

      S_PRE: begin
        oe_n     = 1'b1;
        clkena_n = 1'b1;
        if (cnt == 8'd0) state_n = S_DATA;
        else             cnt_n   = cnt - 8'd1;
      end

      S_DATA: begin
        oe_n     = 1'b1;
        clkena_n = 1'b1;
        if (s_valid) begin
          datain_h_n = s_data[2*WIDTH-1:WIDTH];
          datain_l_n = s_data[WIDTH-1:0];
          if (s_last) begin
            if (POST_CYCLES != 0) begin
              state_n = S_POST;
              cnt_n   = POST_LOAD;
            end else if (TURN_CYCLES != 0) begin
              state_n = S_TURN;
              cnt_n   = TURN_LOAD;
            end else begin
              state_n = S_IDLE;
            end
          end
        end else begin
          underrun_n = 1'b1;
        end
      end

      S_POST: begin
        oe_n     = 1'b1;
        clkena_n = 1'b1;
        if (cnt == 8'd0) begin
          if (TURN_CYCLES != 0) begin
            state_n = S_TURN;
            cnt_n   = TURN_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end

      S_TURN: begin
        // The first turnaround cycle keeps the clock enabled to flush oe=0.
        clkena_n = (cnt == TURN_LOAD);
        if (cnt == 8'd0) state_n = S_IDLE;
        else             cnt_n   = cnt - 8'd1;
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      datain_h <= IDLE_H_BUS;
      datain_l <= IDLE_L_BUS;
      oe       <= 1'b0;
      clkena   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state    <= state_n;
      cnt      <= cnt_n;
      datain_h <= datain_h_n;
      datain_l <= datain_l_n;
      oe       <= oe_n;
      clkena   <= clkena_n;
      underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_ddio_out_burst_ctrl.sv
// Scoreboard bench for ddio_out_burst_ctrl: default, all-zero and all-255
// phase configurations run side by side on one clock.
module tb_ddio_out_burst_ctrl;

  logic        clk = 1'b0;
  logic        areset;
  logic        valid    [3];
  logic        last     [3];
  logic [15:0] data     [3];
  logic        ready    [3];
  logic [7:0]  dh       [3];
  logic [7:0]  dl       [3];
  logic        oe       [3];
  logic        clkena   [3];
  logic        busy     [3];
  logic        underrun [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  bit          pend      [3];
  int          oe_cnt    [3];
  int          clk_cnt   [3];
  int          ur_cnt    [3];
  int          busy_cnt  [3];

  always #5 clk = ~clk;

  // Instance 0: defaults (1/1/2), 1: all zero, 2: all 255.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PP = (g == 0) ? 1 : (g == 1) ? 0 : 255;
    localparam int TT = (g == 0) ? 2 : (g == 1) ? 0 : 255;
    ddio_out_burst_ctrl #(
      .WIDTH(8), .PRE_CYCLES(PP), .POST_CYCLES(PP), .TURN_CYCLES(TT),
      .IDLE_H(1'b0), .IDLE_L(1'b0)
    ) u_dut (
      .clk      (clk),
      .areset   (areset),
      .s_valid  (valid[g]),
      .s_data   (data[g]),
      .s_last   (last[g]),
      .s_ready  (ready[g]),
      .datain_h (dh[g]),
      .datain_l (dl[g]),
      .oe       (oe[g]),
      .clkena   (clkena[g]),
      .busy     (busy[g]),
      .underrun (underrun[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake seen before an edge must show up on datain after it.
  always @(negedge clk) begin
    logic [15:0] e;
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 32'(i), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_h", 32'(dh[i]), 32'(e[15:8]));
          check("beat_l", 32'(dl[i]), 32'(e[7:0]));
        end
      end else if (oe[i]) begin
        check("idle_data", {dh[i], dl[i]}, 32'h0);
      end
      if (oe[i])       oe_cnt[i]++;
      if (clkena[i])   clk_cnt[i]++;
      if (underrun[i]) ur_cnt[i]++;
      if (busy[i])     busy_cnt[i]++;
      pend[i] = valid[i] && ready[i] && !areset;
    end
  end

  // Present one beat and hold it until accepted; waits = cycles with s_ready=0.
  task automatic send_beat(input int i, input logic [15:0] d, input logic l, output int waits);
    bit acc;
    waits = 0;
    valid[i] = 1'b1;
    data[i]  = d;
    last[i]  = l;
    exp_q.push_back(d);
    forever begin
      @(negedge clk);
      acc = ready[i];
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 2000) begin
        check("accept_timeout", 32'(waits), 32'h0);
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (busy[i] && t < 3000) begin
      cycles(1);
      t++;
    end
    check("idle_timeout", 32'(busy[i]), 32'h0);
    cycles(2);
  endtask

  initial begin
    int w, w2, o0, c0, u0, b0;
    areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      last[i]  = 1'b0;
      data[i]  = 16'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_oe",     32'(oe[i]),       32'h0);
      check("rst_clkena", 32'(clkena[i]),   32'h0);
      check("rst_ready",  32'(ready[i]),    32'h0);
      check("rst_busy",   32'(busy[i]),     32'h0);
      check("rst_ur",     32'(underrun[i]), 32'h0);
      check("rst_data",   {dh[i], dl[i]},   32'h0);
    end
    areset = 1'b0;
    cycles(1);

    // Reset in the middle of DATA aborts at once.
    send_beat(0, 16'hDEAD, 1'b0, w);
    send_beat(0, 16'h0101, 1'b0, w);
    valid[0] = 1'b0;
    @(negedge clk);
    #1;
    areset = 1'b1;
    #1;
    check("mid_rst_oe",     32'(oe[0]),     32'h0);
    check("mid_rst_clkena", 32'(clkena[0]), 32'h0);
    check("mid_rst_ready",  32'(ready[0]),  32'h0);
    check("mid_rst_busy",   32'(busy[0]),   32'h0);
    check("mid_rst_data",   {dh[0], dl[0]}, 32'h0);
    @(negedge clk);
    #1;
    areset = 1'b0;
    o0 = oe_cnt[0];
    cycles(3);
    check("post_rst_busy", 32'(busy[0]), 32'h0);
    check("post_rst_no_oe", 32'(oe_cnt[0] - o0), 32'h0);

    // Default 4-beat burst.
    o0 = oe_cnt[0]; c0 = clk_cnt[0]; u0 = ur_cnt[0]; b0 = busy_cnt[0];
    send_beat(0, 16'hA55A, 1'b0, w);
    check("first_wait_default", 32'(w), 32'd2);
    send_beat(0, 16'h0FF0, 1'b0, w);
    send_beat(0, 16'h1234, 1'b0, w);
    send_beat(0, 16'hFFFF, 1'b1, w);
    valid[0] = 1'b0;
    wait_idle(0);
    check("burst_oe_cycles",     32'(oe_cnt[0] - o0),   32'd6);
    check("burst_clkena_cycles", 32'(clk_cnt[0] - c0),  32'd7);
    check("burst_busy_cycles",   32'(busy_cnt[0] - b0), 32'd8);
    check("burst_no_underrun",   32'(ur_cnt[0] - u0),   32'd0);

    // Underrun: two missing cycles between beats 2 and 3.
    o0 = oe_cnt[0]; c0 = clk_cnt[0]; u0 = ur_cnt[0]; b0 = busy_cnt[0];
    send_beat(0, 16'h1111, 1'b0, w);
    send_beat(0, 16'h2222, 1'b0, w);
    valid[0] = 1'b0;
    cycles(2);
    send_beat(0, 16'h3333, 1'b0, w);
    check("underrun_resume_wait", 32'(w), 32'd0);
    send_beat(0, 16'h4444, 1'b1, w);
    valid[0] = 1'b0;
    wait_idle(0);
    check("ur_pulses",    32'(ur_cnt[0] - u0),   32'd2);
    check("ur_oe_cycles", 32'(oe_cnt[0] - o0),   32'd8);
    check("ur_clkena",    32'(clk_cnt[0] - c0),  32'd9);
    check("ur_busy",      32'(busy_cnt[0] - b0), 32'd10);

    // Back-to-back bursts with s_valid held high.
    send_beat(0, 16'hC0DE, 1'b0, w);
    send_beat(0, 16'hBEEF, 1'b1, w);
    send_beat(0, 16'hCAFE, 1'b0, w);
    check("b2b_gap_default", 32'(w), 32'd5);
    send_beat(0, 16'hF00D, 1'b1, w);
    valid[0] = 1'b0;
    wait_idle(0);

    // Zero-length phases.
    o0 = oe_cnt[1]; c0 = clk_cnt[1];
    send_beat(1, 16'h8001, 1'b1, w);
    check("zero_first_wait", 32'(w), 32'd1);
    valid[1] = 1'b0;
    wait_idle(1);
    check("zero_oe_cycles", 32'(oe_cnt[1] - o0),  32'd1);
    check("zero_clkena",    32'(clk_cnt[1] - c0), 32'd1);
    send_beat(1, 16'h7FFE, 1'b1, w);
    send_beat(1, 16'h4BB4, 1'b1, w2);
    check("zero_b2b_gap", 32'(w2), 32'd1);
    valid[1] = 1'b0;
    wait_idle(1);

    // Maximum phase lengths, two single-beat bursts back to back.
    o0 = oe_cnt[2]; c0 = clk_cnt[2]; b0 = busy_cnt[2];
    send_beat(2, 16'h5AA5, 1'b1, w);
    check("max_pre_wait", 32'(w), 32'd256);
    send_beat(2, 16'h3C3C, 1'b1, w2);
    check("max_b2b_gap", 32'(w2), 32'd766);
    valid[2] = 1'b0;
    wait_idle(2);
    check("max_oe_cycles", 32'(oe_cnt[2] - o0),   32'd1022);
    check("max_clkena",    32'(clk_cnt[2] - c0),  32'd1024);
    check("max_busy",      32'(busy_cnt[2] - b0), 32'd1532);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
